// File: rtl/sregister_piso.sv
// -----------------------------------------------------------------------------
// sregister_piso
//   Parallel-in, serial-out word shift register. A single parallel load
//   captures DEPTH words of WIDTH bits; they are then emitted one word per
//   accepted transfer on a valid/ready stream, word 0 first.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   pin         parallel load data, word k = pin[k*WIDTH +: WIDTH]
//   load_valid  source presents pin
//   load_ready  a load can be accepted this cycle (combinational from
//               sout_ready, the only in->out combinational path)
//   sout        current head word (stage 0)
//   sout_valid  sout holds a valid word
//   sout_ready  consumer accepts sout this cycle
//   count       words still to be emitted, including the head
//   busy        FSM is in SHIFT
// -----------------------------------------------------------------------------
module sregister_piso #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH*DEPTH-1:0] pin,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic [WIDTH-1:0]       sout,
  output logic                   sout_valid,
  input  logic                   sout_ready,
  output logic [CW-1:0]          count,
  output logic                   busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Per-stage candidate values for a load and for a shift.
  logic [WIDTH-1:0] load_word  [DEPTH];
  logic [WIDTH-1:0] shift_word [DEPTH];

  logic load_fire;
  logic xfer;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      assign load_word[gi] = pin[gi*WIDTH +: WIDTH];
      if (gi == DEPTH - 1) begin : g_top
        // Top stage back-fills with zero so stage 0 reads 0 once drained.
        assign shift_word[gi] = '0;
      end else begin : g_mid
        assign shift_word[gi] = stage_q[gi+1];
      end
    end
  endgenerate

  // A new load is possible when empty, or when the last word leaves this
  // cycle, which lets back-to-back loads stream without a bubble.
  // Held low while reset is asserted.
  assign load_ready = reset &&
                      ((count_q == '0) || ((count_q == CW'(1)) && sout_ready));
  assign load_fire  = load_valid && load_ready;
  assign xfer       = valid_q && sout_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end

    if (load_fire) begin
      // Takes priority over the simultaneous last transfer: the old head is
      // consumed and replaced by the new word 0.
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = load_word[i];
      end
      count_d = CW'(DEPTH);
      state_d = ST_SHIFT;
    end else if (xfer) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = shift_word[i];
      end
      count_d = count_q - CW'(1);
      state_d = (count_q == CW'(1)) ? ST_IDLE : ST_SHIFT;
    end

    valid_d = (state_d == ST_SHIFT);
    busy_d  = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign sout       = stage_q[0];
  assign sout_valid = valid_q;
  assign count      = count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sregister_piso.sv
// -----------------------------------------------------------------------------
// tb_sregister_piso
//   Scoreboard bench for sregister_piso. Load tasks push hand-computed
//   expected (word, count) pairs; a monitor pops and compares on every
//   accepted output transfer. Direct checks cover reset, stall, ignored
//   loads, gapless streaming and idle behaviour.
// -----------------------------------------------------------------------------
module tb_sregister_piso;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic                   clk;
  logic                   reset;
  logic [WIDTH*DEPTH-1:0] pin;
  logic                   load_valid;
  logic                   load_ready;
  logic [WIDTH-1:0]       sout;
  logic                   sout_valid;
  logic                   sout_ready;
  logic [CW-1:0]          count;
  logic                   busy;

  sregister_piso #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pin        (pin),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .count      (count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_word_q [$];
  logic [CW-1:0]    exp_cnt_q  [$];

  logic gap_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted output transfer against the scoreboard.
  always @(negedge clk) begin
    if (reset && sout_valid && sout_ready) begin
      if (exp_word_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got word %0h count %0d, expected none", sout, count);
      end else begin
        logic [WIDTH-1:0] w;
        logic [CW-1:0]    c;
        w = exp_word_q.pop_front();
        c = exp_cnt_q.pop_front();
        chk("out_word", 32'(sout), 32'(w));
        chk("out_count", 32'(count), 32'(c));
        $display("xfer: sout=%0h count=%0d (exp %0h/%0d)", sout, count, w, c);
      end
    end
  end

  // Gap watcher for the back-to-back streaming test.
  always @(negedge clk) begin
    if (gap_en) chk("stream_gapless_valid", 32'(sout_valid), 32'd1);
  end

  // Present a load, wait (bounded) for acceptance, push expected words.
  task automatic do_load(input logic [WIDTH*DEPTH-1:0] data,
                         input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                         input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3,
                         input bit keep);
    bit ok;
    ok = 1'b0;
    pin        = data;
    load_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (load_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: load_ready stayed 0, required 1");
    end else begin
      exp_word_q.push_back(e0); exp_cnt_q.push_back(CW'(4));
      exp_word_q.push_back(e1); exp_cnt_q.push_back(CW'(3));
      exp_word_q.push_back(e2); exp_cnt_q.push_back(CW'(2));
      exp_word_q.push_back(e3); exp_cnt_q.push_back(CW'(1));
      $display("load: pin=%04h accepted", data);
    end
    @(posedge clk);
    #1;
    if (!keep) load_valid = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard is empty, then check idle state.
  task automatic wait_drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (exp_word_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout_%s: %0d words left, required 0", tag, exp_word_q.size());
    end
    chk({tag, "_idle_valid"}, 32'(sout_valid), 32'd0);
    chk({tag, "_idle_count"}, 32'(count), 32'd0);
    chk({tag, "_idle_busy"},  32'(busy), 32'd0);
    chk({tag, "_idle_sout"},  32'(sout), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    pin        = '0;
    load_valid = 1'b0;
    sout_ready = 1'b0;

    // 1. Reset then load.
    repeat (2) @(negedge clk);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_valid", 32'(sout_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    sout_ready = 1'b1;
    #1;
    chk("post_rst_load_ready", 32'(load_ready), 32'd1);
    do_load(16'h4321, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    wait_drain("t1");

    // 2. Stall.
    sout_ready = 1'b0;
    do_load(16'hDCBA, 4'hA, 4'hB, 4'hC, 4'hD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sout", 32'(sout), 32'hA);
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_valid", 32'(sout_valid), 32'd1);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    sout_ready = 1'b1;
    wait_drain("t2");

    // 3. Back-to-back loads, gapless stream.
    do_load(16'h4321, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    gap_en = 1'b1;
    do_load(16'h8765, 4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (exp_word_q.size() == 0) break;
    end
    gap_en = 1'b0;
    wait_drain("t3");

    // 4. Ignored load at count==3.
    do_load(16'h4321, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    @(posedge clk);
    #1;
    chk("ign_pre_count", 32'(count), 32'd3);
    pin        = 16'hFFFF;
    load_valid = 1'b1;
    @(negedge clk);
    chk("ign_load_ready", 32'(load_ready), 32'd0);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    wait_drain("t4");

    // 5. Asynchronous reset mid-operation.
    do_load(16'h4321, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (exp_word_q.size() == 2) break;
    end
    #1;
    chk("mid_pre_count", 32'(count), 32'd2);
    #2;
    reset = 1'b0;
    exp_word_q.delete();
    exp_cnt_q.delete();
    #1;
    chk("mid_rst_sout", 32'(sout), 32'd0);
    chk("mid_rst_valid", 32'(sout_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    do_load(16'h9876, 4'h6, 4'h7, 4'h8, 4'h9, 1'b0);
    wait_drain("t5");

    // 6. Spurious ready while idle.
    sout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("spur_count", 32'(count), 32'd0);
      chk("spur_valid", 32'(sout_valid), 32'd0);
      chk("spur_sout", 32'(sout), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
